// File: rtl/mmio_pkg.sv
// ============================================================================
// Module  : mmio_pkg
// Purpose : Register map, status bit positions and the seven-segment decoder
//           shared by the memory-mapped I/O unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

  // Size of the decoded I/O window in bytes (16 word registers)
  localparam int unsigned IO_WINDOW_BYTES = 64;

  // Byte offsets from the window base; the low two bits are never decoded
  localparam logic [5:0] OFF_HEXV  = 6'h00;
  localparam logic [5:0] OFF_LEDRV = 6'h04;
  localparam logic [5:0] OFF_LEDGV = 6'h08;
  localparam logic [5:0] OFF_KDATA = 6'h10;
  localparam logic [5:0] OFF_KSTAT = 6'h14;
  localparam logic [5:0] OFF_SDATA = 6'h18;
  localparam logic [5:0] OFF_SSTAT = 6'h1C;
  localparam logic [5:0] OFF_TCNT  = 6'h20;
  localparam logic [5:0] OFF_TLIM  = 6'h24;
  localparam logic [5:0] OFF_TCTL  = 6'h28;

  // Status bit positions
  localparam int unsigned KSTAT_OVR_LSB = 16;
  localparam int unsigned SSTAT_CHG_BIT = 0;
  localparam int unsigned SSTAT_OVR_BIT = 1;
  localparam int unsigned TCTL_EN_BIT   = 0;
  localparam int unsigned TCTL_RDY_BIT  = 1;
  localparam int unsigned TCTL_OVR_BIT  = 2;

  // Board seven-segment decoder: segments active-low, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_input_sync.sv
// ============================================================================
// Module  : mmio_input_sync
// Purpose : Two-flop synchroniser for asynchronous board inputs, with an
//           optional per-bit debouncer (enabled by macro MMIO_DEBOUNCE_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_input_sync #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Synchroniser chain next state
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  // Synchroniser flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;

    // Count consecutive disagreeing cycles; adopt the new level on the last one
    always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (sync_q[i] == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        db_d  = sync_q[i];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Debounce state flops
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        db_q  <= db_d;
      end
    end

    assign dout[i] = db_q;
  end
`else
  assign dout = sync_q;
`endif

endmodule

`default_nettype wire

// File: rtl/mmio_unit.sv
// ============================================================================
// Module  : mmio_unit
// Purpose : Memory-mapped I/O window for the memory stage: LED/HEX output
//           registers, synchronised SW/KEY inputs with sticky W1C status,
//           and a prescaled tick timer. Loads return registered data one
//           cycle later. Optional debounce: macro MMIO_DEBOUNCE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_unit
  import mmio_pkg::*;
#(
  parameter int unsigned       DBITS           = 32,
  parameter logic [DBITS-1:0]  IO_BASE         = 'hF000_0000,
  parameter int unsigned       NUM_SW          = 10,
  parameter int unsigned       NUM_KEY         = 4,
  parameter int unsigned       NUM_LEDR        = 10,
  parameter int unsigned       NUM_LEDG        = 8,
  parameter int unsigned       HEX_DIGITS      = 4,
  parameter int unsigned       TIMER_DIV       = 50000,
  parameter int unsigned       DEBOUNCE_CYCLES = 250000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DBITS-1:0]        addr,
  input  logic                    isLoad,
  input  logic                    isStore,
  input  logic [DBITS-1:0]        wrData,
  output logic [DBITS-1:0]        rdData,
  output logic                    rdValid,
  output logic                    ioHit,
  input  logic [NUM_SW-1:0]       SW,
  input  logic [NUM_KEY-1:0]      KEY,
  output logic [NUM_LEDR-1:0]     LEDR,
  output logic [NUM_LEDG-1:0]     LEDG,
  output logic [7*HEX_DIGITS-1:0] HEX
);

  localparam int unsigned HEXW = 4 * HEX_DIGITS;
  localparam int unsigned PW   = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TIMER_DIV - 1);

  // ---- synchronised inputs ------------------------------------------------
  logic [NUM_SW-1:0]  sw_s;
  logic [NUM_KEY-1:0] key_s;

  mmio_input_sync #(.WIDTH(NUM_SW), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_sync (
    .clk(clk), .reset(reset), .din(SW), .dout(sw_s)
  );

  mmio_input_sync #(.WIDTH(NUM_KEY), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_sync (
    .clk(clk), .reset(reset), .din(KEY), .dout(key_s)
  );

  // ---- state --------------------------------------------------------------
  logic [HEXW-1:0]     hexv_q, hexv_d;
  logic [NUM_LEDR-1:0] ledr_q, ledr_d;
  logic [NUM_LEDG-1:0] ledg_q, ledg_d;
  logic [NUM_SW-1:0]   sw_prev_q, sw_prev_d;
  logic [NUM_KEY-1:0]  key_prev_q, key_prev_d;
  logic [NUM_KEY-1:0]  kready_q, kready_d;
  logic [NUM_KEY-1:0]  kover_q, kover_d;
  logic                schg_q, schg_d;
  logic                sover_q, sover_d;
  logic [DBITS-1:0]    tcnt_q, tcnt_d;
  logic [DBITS-1:0]    tlim_q, tlim_d;
  logic                ten_q, ten_d;
  logic                tready_q, tready_d;
  logic                tover_q, tover_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [DBITS-1:0]    rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  // ---- decode -------------------------------------------------------------
  logic [DBITS-1:0]   w_off;
  logic [5:0]         w_reg;
  logic               w_st, w_ld;
  logic [NUM_KEY-1:0] w_press;
  logic               w_sw_chg;
  logic               w_tick;
  logic [DBITS-1:0]   w_rdata;

  // Unsigned offset compare also rejects addresses below the base (they wrap high)
  assign w_off    = addr - IO_BASE;
  assign ioHit    = (w_off < DBITS'(IO_WINDOW_BYTES));
  assign w_reg    = {w_off[5:2], 2'b00};
  assign w_st     = isStore & ioHit;
  assign w_ld     = isLoad & ~isStore & ioHit;
  // Key press = synced (active-low) key falls, i.e. the inverted level rises
  assign w_press  = key_prev_q & ~key_s;
  assign w_sw_chg = |(sw_s ^ sw_prev_q);
  assign w_tick   = ten_q && (presc_q == PRESC_LAST);

  // Register writes, W1C clears, then event sets so a coincident event is kept
  always_comb begin
    hexv_d     = hexv_q;
    ledr_d     = ledr_q;
    ledg_d     = ledg_q;
    kready_d   = kready_q;
    kover_d    = kover_q;
    schg_d     = schg_q;
    sover_d    = sover_q;
    tcnt_d     = tcnt_q;
    tlim_d     = tlim_q;
    ten_d      = ten_q;
    tready_d   = tready_q;
    tover_d    = tover_q;
    presc_d    = presc_q;
    sw_prev_d  = sw_s;
    key_prev_d = key_s;

    if (ten_q) begin
      presc_d = w_tick ? '0 : presc_q + 1'b1;
    end

    if (w_tick) begin
      if ((tlim_q != '0) && (tcnt_q == tlim_q - 1'b1)) begin
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end

    if (w_st) begin
      case (w_reg)
        OFF_HEXV:  hexv_d = wrData[HEXW-1:0];
        OFF_LEDRV: ledr_d = wrData[NUM_LEDR-1:0];
        OFF_LEDGV: ledg_d = wrData[NUM_LEDG-1:0];
        OFF_KSTAT: begin
          kready_d = kready_q & ~wrData[NUM_KEY-1:0];
          kover_d  = kover_q & ~wrData[KSTAT_OVR_LSB +: NUM_KEY];
        end
        OFF_SSTAT: begin
          schg_d  = schg_q & ~wrData[SSTAT_CHG_BIT];
          sover_d = sover_q & ~wrData[SSTAT_OVR_BIT];
        end
        OFF_TCNT:  tcnt_d = wrData;
        OFF_TLIM:  tlim_d = wrData;
        OFF_TCTL: begin
          ten_d    = wrData[TCTL_EN_BIT];
          tready_d = tready_q & ~wrData[TCTL_RDY_BIT];
          tover_d  = tover_q & ~wrData[TCTL_OVR_BIT];
          if (!wrData[TCTL_EN_BIT]) begin
            presc_d = '0;
          end
        end
        default: ;
      endcase
    end

    // Overrun tests the pre-clear ready/changed values
    kover_d  = kover_d | (w_press & kready_q);
    kready_d = kready_d | w_press;
    if (w_sw_chg) begin
      sover_d = sover_d | schg_q;
      schg_d  = 1'b1;
    end
    if (w_tick && (tlim_q != '0) && (tcnt_q == tlim_q - 1'b1)) begin
      tover_d  = tover_d | tready_q;
      tready_d = 1'b1;
    end
  end

  // Load data mux; unmapped offsets read zero
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      OFF_HEXV:  w_rdata[HEXW-1:0]     = hexv_q;
      OFF_LEDRV: w_rdata[NUM_LEDR-1:0] = ledr_q;
      OFF_LEDGV: w_rdata[NUM_LEDG-1:0] = ledg_q;
      OFF_KDATA: w_rdata[NUM_KEY-1:0]  = ~key_s;
      OFF_KSTAT: begin
        w_rdata[NUM_KEY-1:0]              = kready_q;
        w_rdata[KSTAT_OVR_LSB +: NUM_KEY] = kover_q;
      end
      OFF_SDATA: w_rdata[NUM_SW-1:0] = sw_s;
      OFF_SSTAT: begin
        w_rdata[SSTAT_CHG_BIT] = schg_q;
        w_rdata[SSTAT_OVR_BIT] = sover_q;
      end
      OFF_TCNT:  w_rdata = tcnt_q;
      OFF_TLIM:  w_rdata = tlim_q;
      OFF_TCTL: begin
        w_rdata[TCTL_EN_BIT]  = ten_q;
        w_rdata[TCTL_RDY_BIT] = tready_q;
        w_rdata[TCTL_OVR_BIT] = tover_q;
      end
      default: ;
    endcase
    rd_data_d  = w_ld ? w_rdata : rd_data_q;
    rd_valid_d = w_ld;
  end

  // All architectural state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hexv_q     <= '0;
      ledr_q     <= '0;
      ledg_q     <= '0;
      sw_prev_q  <= '0;
      key_prev_q <= '0;
      kready_q   <= '0;
      kover_q    <= '0;
      schg_q     <= 1'b0;
      sover_q    <= 1'b0;
      tcnt_q     <= '0;
      tlim_q     <= '0;
      ten_q      <= 1'b0;
      tready_q   <= 1'b0;
      tover_q    <= 1'b0;
      presc_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      hexv_q     <= hexv_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      sw_prev_q  <= sw_prev_d;
      key_prev_q <= key_prev_d;
      kready_q   <= kready_d;
      kover_q    <= kover_d;
      schg_q     <= schg_d;
      sover_q    <= sover_d;
      tcnt_q     <= tcnt_d;
      tlim_q     <= tlim_d;
      ten_q      <= ten_d;
      tready_q   <= tready_d;
      tover_q    <= tover_d;
      presc_q    <= presc_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rdData  = rd_data_q;
  assign rdValid = rd_valid_q;
  assign LEDR    = ledr_q;
  assign LEDG    = ledg_q;

  for (genvar i = 0; i < HEX_DIGITS; i++) begin : g_hex
    assign HEX[7*i +: 7] = seg7_decode(hexv_q[4*i +: 4]);
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_unit.sv
// ============================================================================
// Module  : tb_mmio_unit
// Purpose : Self-checking bench for mmio_unit (TIMER_DIV=4, DEBOUNCE_CYCLES=8;
//           debounce scenario active when MMIO_DEBOUNCE_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_unit;

  localparam logic [31:0] BASE = 32'hF000_0000;
  localparam int TDIV = 4;
  localparam int DEB  = 8;
`ifdef MMIO_DEBOUNCE_EN
  localparam int IN_LAT = 3 + DEB;
`else
  localparam int IN_LAT = 3;
`endif

  localparam logic [5:0] R_HEXV = 6'h00, R_LEDR = 6'h04, R_LEDG = 6'h08,
                         R_KDAT = 6'h10, R_KST = 6'h14, R_SDAT = 6'h18,
                         R_SST = 6'h1C, R_TCNT = 6'h20, R_TLIM = 6'h24, R_TCTL = 6'h28;

  // Active-low {g..a} digit patterns of the board decoder
  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0, wrData = '0;
  logic        isLoad = 1'b0, isStore = 1'b0;
  logic [9:0]  SW = '0;
  logic [3:0]  KEY = '1;
  logic [31:0] rdData;
  logic        rdValid, ioHit;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;
  logic [27:0] HEX;

  int checks = 0;
  int failures = 0;

  mmio_unit #(
    .DBITS(32), .IO_BASE(BASE), .NUM_SW(10), .NUM_KEY(4), .NUM_LEDR(10),
    .NUM_LEDG(8), .HEX_DIGITS(4), .TIMER_DIV(TDIV), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .isLoad(isLoad), .isStore(isStore),
    .wrData(wrData), .rdData(rdData), .rdValid(rdValid), .ioHit(ioHit),
    .SW(SW), .KEY(KEY), .LEDR(LEDR), .LEDG(LEDG), .HEX(HEX)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [27:0] hex_exp(input logic [15:0] v);
    logic [27:0] h;
    for (int i = 0; i < 4; i++) h[7*i +: 7] = SEG_TAB[v[4*i +: 4]];
    return h;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_store(input logic [5:0] off, input logic [31:0] d);
    addr = BASE + {26'd0, off};
    wrData = d;
    isStore = 1'b1;
    step(1);
    isStore = 1'b0;
  endtask

  task automatic bus_load(input logic [5:0] off, output logic [31:0] d, output logic v);
    addr = BASE + {26'd0, off};
    isLoad = 1'b1;
    step(1);
    isLoad = 1'b0;
    d = rdData;
    v = rdValid;
  endtask

  // Power-on and asynchronous mid-run reset
  task automatic test_reset();
    logic [31:0] d;
    logic v;
    #1;
    checks++; if (LEDR !== 10'h0 || LEDG !== 8'h0) begin failures++; $display("FAIL por_leds LEDR=%h LEDG=%h want 0", LEDR, LEDG); end
    checks++; if (HEX !== hex_exp(16'h0)) begin failures++; $display("FAIL por_hex got=%h want=%h", HEX, hex_exp(16'h0)); end
    step(3);
    reset = 1'b1;
    step(IN_LAT + DEB + 4);
    bus_store(R_LEDR, 32'h155);
    bus_store(R_LEDG, 32'hA5);
    bus_store(R_HEXV, 32'h1234);
    checks++; if (HEX !== hex_exp(16'h1234)) begin failures++; $display("FAIL hex_1234 got=%h want=%h", HEX, hex_exp(16'h1234)); end
    bus_load(R_LEDG, d, v);
    checks++; if (v !== 1'b1 || d !== 32'hA5) begin failures++; $display("FAIL pre_reset_load v=%b d=%h want 1/a5", v, d); end
    #2 reset = 1'b0;
    #1;
    checks++; if (LEDR !== 10'h0 || LEDG !== 8'h0) begin failures++; $display("FAIL async_rst_leds LEDR=%h LEDG=%h want 0", LEDR, LEDG); end
    checks++; if (HEX !== hex_exp(16'h0)) begin failures++; $display("FAIL async_rst_hex got=%h want=%h", HEX, hex_exp(16'h0)); end
    checks++; if (rdValid !== 1'b0 || rdData !== 32'h0) begin failures++; $display("FAIL async_rst_rd v=%b d=%h want 0/0", rdValid, rdData); end
    step(2);
    reset = 1'b1;
    step(IN_LAT + DEB + 4);
  endtask

  // Register read/write, unmapped offsets, load+store collision
  task automatic test_regs();
    logic [31:0] d, mdl [5], mask [5], keep;
    logic [5:0]  offs [5];
    logic v;
    int s, j;
    offs = '{R_HEXV, R_LEDR, R_LEDG, R_TLIM, R_TCNT};
    mask = '{32'hFFFF, 32'h3FF, 32'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    mdl  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    bus_store(R_LEDR, 32'h3FF);
    mdl[1] = 32'h3FF;
    checks++; if (LEDR !== 10'h3FF) begin failures++; $display("FAIL ledr_store got=%h want=3ff", LEDR); end
    bus_load(R_LEDR, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h3FF) begin failures++; $display("FAIL ledr_load v=%b d=%h want 1/3ff", v, d); end
    step(1);
    checks++; if (rdValid !== 1'b0) begin failures++; $display("FAIL rdvalid_pulse got=%b want 0", rdValid); end
    bus_load(6'h30, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL unmapped_load v=%b d=%h want 1/0", v, d); end
    for (int i = 0; i < 30; i++) begin
      s = $urandom_range(0, 4);
      d = $urandom;
      bus_store(offs[s], d);
      mdl[s] = d & mask[s];
      j = $urandom_range(0, 4);
      bus_load(offs[j], d, v);
      checks++; if (v !== 1'b1 || d !== mdl[j]) begin failures++; $display("FAIL rand_rw off=%h v=%b got=%h want=%h", offs[j], v, d, mdl[j]); end
    end
    bus_store(6'h0C, $urandom);
    bus_store(6'h2C, $urandom);
    bus_store(6'h3C, $urandom);
    bus_load(6'h0C, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_wr_ignored got=%h want 0", d); end
    checks++; if (LEDR !== mdl[1][9:0] || LEDG !== mdl[2][7:0] || HEX !== hex_exp(mdl[0][15:0])) begin
      failures++; $display("FAIL outputs LEDR=%h LEDG=%h HEX=%h want %h %h %h", LEDR, LEDG, HEX, mdl[1][9:0], mdl[2][7:0], hex_exp(mdl[0][15:0]));
    end
    keep = rdData;
    addr = BASE + 32'h04; wrData = 32'h2AA; isLoad = 1'b1; isStore = 1'b1;
    step(1);
    isLoad = 1'b0; isStore = 1'b0;
    checks++; if (rdValid !== 1'b0 || rdData !== keep || LEDR !== 10'h2AA) begin
      failures++; $display("FAIL ld_st_collide v=%b d=%h LEDR=%h want 0/%h/2aa", rdValid, rdData, LEDR, keep);
    end
  endtask

  // Window boundaries and non-window loads
  task automatic test_window();
    logic [31:0] keep;
    addr = BASE + 32'h3C; #1;
    checks++; if (ioHit !== 1'b1) begin failures++; $display("FAIL hit_top got=%b want 1", ioHit); end
    addr = BASE + 32'h40; #1;
    checks++; if (ioHit !== 1'b0) begin failures++; $display("FAIL hit_above got=%b want 0", ioHit); end
    addr = BASE - 32'h4; #1;
    checks++; if (ioHit !== 1'b0) begin failures++; $display("FAIL hit_below got=%b want 0", ioHit); end
    keep = rdData;
    addr = 32'h0000_1000; isLoad = 1'b1; #1;
    checks++; if (ioHit !== 1'b0) begin failures++; $display("FAIL hit_mem got=%b want 0", ioHit); end
    step(1);
    isLoad = 1'b0;
    checks++; if (rdValid !== 1'b0 || rdData !== keep) begin failures++; $display("FAIL nonwin_load v=%b d=%h want 0/%h", rdValid, rdData, keep); end
  endtask

  // Key press status: latency, overrun, W1C, coincident set/clear, random model
  task automatic test_keys();
    logic [31:0] d, e;
    logic v;
    logic [3:0] rdy, ovr, m, cm, om;
    KEY[2] = 1'b0;
    step(IN_LAT - 1);
    bus_load(R_KST, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL key_latency_early got=%h want 0", d); end
    bus_load(R_KST, d, v);
    checks++; if (d !== 32'h4) begin failures++; $display("FAIL key_ready got=%h want 4", d); end
    bus_load(R_KDAT, d, v);
    checks++; if (d !== 32'h4) begin failures++; $display("FAIL kdata got=%h want 4", d); end
    KEY[2] = 1'b1; step(IN_LAT + 2);
    KEY[2] = 1'b0; step(IN_LAT + 1);
    bus_load(R_KST, d, v);
    checks++; if (d !== 32'h0004_0004) begin failures++; $display("FAIL key_overrun got=%h want 40004", d); end
    KEY[2] = 1'b1; step(IN_LAT + 2);
    bus_store(R_KST, 32'h0004_0004);
    bus_load(R_KST, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL key_w1c got=%h want 0", d); end
    KEY[2] = 1'b0; step(IN_LAT + 1);
    KEY[2] = 1'b1; step(IN_LAT + 2);
    KEY[2] = 1'b0; step(IN_LAT - 1);
    bus_store(R_KST, 32'h4);
    bus_load(R_KST, d, v);
    checks++; if (d !== 32'h0004_0004) begin failures++; $display("FAIL key_set_wins got=%h want 40004", d); end
    KEY[2] = 1'b1; step(IN_LAT + 2);
    bus_store(R_KST, 32'h000F_000F);
    rdy = '0; ovr = '0;
    for (int r = 0; r < 6; r++) begin
      m = 4'($urandom_range(1, 15));
      KEY = ~m; step(IN_LAT + 1);
      KEY = 4'hF; step(IN_LAT + 2);
      ovr = ovr | (rdy & m);
      rdy = rdy | m;
      if (r == 3) begin
        cm = 4'($urandom_range(0, 15));
        om = 4'($urandom_range(0, 15));
        bus_store(R_KST, {12'd0, om, 12'd0, cm});
        rdy = rdy & ~cm;
        ovr = ovr & ~om;
      end
    end
    e = {12'd0, ovr, 12'd0, rdy};
    bus_load(R_KST, d, v);
    checks++; if (d !== e) begin failures++; $display("FAIL key_random got=%h want=%h", d, e); end
    bus_store(R_KST, 32'h000F_000F);
  endtask

  // Switch change status with a change-count model
  task automatic test_switches();
    logic [31:0] d, e;
    logic v;
    logic [9:0] nv;
    int n;
    SW = 10'h001; step(IN_LAT + 1);
    bus_load(R_SST, d, v);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL sw_changed got=%h want 1", d); end
    bus_load(R_SDAT, d, v);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL sdata got=%h want 1", d); end
    SW = 10'h000; step(IN_LAT + 1);
    bus_load(R_SST, d, v);
    checks++; if (d !== 32'h3) begin failures++; $display("FAIL sw_overrun got=%h want 3", d); end
    bus_store(R_SST, 32'h3);
    bus_load(R_SST, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL sw_w1c got=%h want 0", d); end
    n = 0;
    for (int r = 0; r < 5; r++) begin
      nv = 10'($urandom_range(0, 1023));
      if (r == 2) nv = SW;
      if (nv != SW) n++;
      SW = nv; step(IN_LAT + 2);
    end
    e = {30'd0, n >= 2, n >= 1};
    bus_load(R_SST, d, v);
    checks++; if (d !== e) begin failures++; $display("FAIL sw_random got=%h want=%h", d, e); end
    bus_load(R_SDAT, d, v);
    checks++; if (d !== {22'd0, SW}) begin failures++; $display("FAIL sdata_random got=%h want=%h", d, SW); end
    bus_store(R_SST, 32'h3);
  endtask

  // Timer: tick-count arithmetic, ready/overrun, store-vs-tick, free-run wrap
  task automatic test_timer();
    logic [31:0] d, e;
    logic v;
    bus_store(R_TCTL, 32'h6);
    bus_store(R_TLIM, 32'd3);
    bus_store(R_TCNT, 32'd0);
    bus_store(R_TCTL, 32'h1);
    addr = BASE + 32'h20; isLoad = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step(1);
      e = 32'(((k - 1) / TDIV) % 3);
      checks++; if (rdData !== e) begin failures++; $display("FAIL tcnt_seq k=%0d got=%h want=%h", k, rdData, e); end
    end
    isLoad = 1'b0;
    bus_load(R_TCTL, d, v);
    checks++; if (d !== 32'h7) begin failures++; $display("FAIL tctl_ready_ovr got=%h want 7", d); end
    bus_store(R_TCTL, 32'h6);
    bus_load(R_TCTL, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL tctl_clear got=%h want 0", d); end
    bus_store(R_TCNT, 32'd0);
    bus_store(R_TCTL, 32'h1);
    step(TDIV - 1);
    bus_store(R_TCNT, 32'd7);
    bus_load(R_TCNT, d, v);
    checks++; if (d !== 32'd7) begin failures++; $display("FAIL tcnt_store_wins got=%h want 7", d); end
    step(TDIV - 1);
    bus_load(R_TCNT, d, v);
    checks++; if (d !== 32'd8) begin failures++; $display("FAIL tcnt_after_store got=%h want 8", d); end
    bus_store(R_TCTL, 32'h6);
    bus_store(R_TLIM, 32'd0);
    bus_store(R_TCNT, 32'hFFFF_FFFE);
    bus_store(R_TCTL, 32'h1);
    step(2 * TDIV);
    bus_load(R_TCNT, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL tcnt_wrap got=%h want 0", d); end
    bus_load(R_TCTL, d, v);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL tlim0_noready got=%h want 1", d); end
    bus_store(R_TCTL, 32'h6);
  endtask

`ifdef MMIO_DEBOUNCE_EN
  // Short glitch rejected, stable press accepted
  task automatic test_debounce();
    logic [31:0] d;
    logic v;
    KEY[1] = 1'b0; step(5);
    KEY[1] = 1'b1; step(20);
    bus_load(R_KST, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL db_glitch got=%h want 0", d); end
    KEY[1] = 1'b0; step(DEB + 6);
    bus_load(R_KST, d, v);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL db_press got=%h want 2", d); end
    KEY[1] = 1'b1; step(DEB + 6);
    bus_store(R_KST, 32'h000F_000F);
  endtask
`endif

  initial begin
    test_reset();
    test_regs();
    test_window();
    test_keys();
    test_switches();
    test_timer();
`ifdef MMIO_DEBOUNCE_EN
    test_debounce();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmio_unit.md
Name: mmio_unit

Overview:
- Parametrised memory-mapped I/O unit; the successor to the fixed SW/KEY/LEDR/LEDG/HEX register set in the memory stage.
- Decodes a load/store bus into an I/O address window.
- Provides LED/HEX output registers, synchronised switch and key inputs, and sticky edge-capture status with write-1-to-clear.
- Includes a programmable tick timer; load data is registered, one-cycle latency.

Parameters:
DBITS, 32, bus data/address width
IO_BASE, 32'hF000_0000, base byte address of the I/O window (window = 64 bytes, word-aligned)
NUM_SW, 10, switch inputs
NUM_KEY, 4, key inputs (board keys active-low)
NUM_LEDR, 10, red LED outputs
NUM_LEDG, 8, green LED outputs
HEX_DIGITS, 4, seven-segment digits driven
TIMER_DIV, 50000, clk cycles per timer tick (≥1)
DEBOUNCE_CYCLES, 250000, stable cycles required (used only with optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
addr  in  DBITS  byte address of current access
isLoad  in  1  load strobe, single cycle
isStore  in  1  store strobe, single cycle
wrData  in  DBITS  store data
rdData  out  DBITS  registered load data
rdValid  out  1  pulses one cycle after an I/O-window load
ioHit  out  1  combinational: addr inside I/O window (memory stage muxes rdData vs DataMemory)
SW  in  NUM_SW  raw switches
KEY  in  NUM_KEY  raw keys, active-low
LEDR  out  NUM_LEDR  red LEDs
LEDG  out  NUM_LEDG  green LEDs
HEX  out  7*HEX_DIGITS  segments; digit i at [7i+6:7i]

Behaviour:
- Register map (byte offsets from IO_BASE, word-aligned; addr[1:0] ignored):
  - 0x00 HEXV RW [4*HEX_DIGITS-1:0]
  - 0x04 LEDRV RW
  - 0x08 LEDGV RW
  - 0x10 KDATA RO: inverted synced KEY, 1 = pressed
  - 0x14 KSTAT: [NUM_KEY-1:0] press-ready, [NUM_KEY+15:16] overrun; W1C
  - 0x18 SDATA RO: synced SW
  - 0x1C SSTAT: bit0 changed, bit1 overrun; W1C
  - 0x20 TCNT RW
  - 0x24 TLIM RW
  - 0x28 TCTL: bit0 enable RW, bit1 ready W1C, bit2 overrun W1C
  - Unmapped offsets read 0; writes to them are ignored.
- Reset (reset=0, async): all registers, sync flops, prescaler, rdData, rdValid = 0; LEDR/LEDG = 0; HEX shows "0" on every digit.
- Inputs pass through a 2-flop synchroniser. Edge/change detection compares against a third registered copy.
- KEY press = rising edge of inverted synced key:
  - sets ready[i];
  - if ready[i] is already 1, also sets overrun[i].
- SW change (any bit differs from previous sample):
  - sets changed;
  - if changed is already 1, also sets overrun.
- W1C and a new event in the same cycle: the set wins (event never lost). The overrun check uses the pre-clear value.
- Timer:
  - The prescaler counts 0..TIMER_DIV-1 while enable=1 and emits a tick on wrap. The prescaler resets to 0 when enable is written 0.
  - On tick: if TLIM≠0 and TCNT==TLIM-1, TCNT←0 and ready←1 (overrun←1 if ready already 1). Otherwise TCNT←TCNT+1, mod 2^DBITS.
  - TLIM=0: free-running, never sets ready.
  - Store to TCNT in the same cycle as a tick: the store wins.
- Stores take effect on the clock edge of the isStore cycle. A load in the cycle after a store returns the new value.
- Load: rdData captured at the edge of the isLoad cycle; rdValid=1 the following cycle. Non-window load: rdValid stays 0 and rdData holds its value.
- isLoad and isStore both high: treated as store only.
- HEX: each nibble of HEXV drives the existing seven-segment decoder.

Optional Feature:
- Macro MMIO_DEBOUNCE_EN.
- Defined:
  - each synced SW/KEY bit feeds a per-bit counter;
  - the debounced value updates only after DEBOUNCE_CYCLES consecutive cycles differing from the current debounced value;
  - the counter clears whenever the input matches the debounced value;
  - KDATA, SDATA and edge detection use the debounced values.
- Undefined: no counters; sync output used directly (3-cycle input-to-register latency).

Decomposition:
- Package mmio_pkg: register offset localparams, KSTAT/TCTL bit-position constants, window size.
- Sub-module mmio_input_sync (parameter WIDTH): 2-flop sync plus optional debounce, instantiated for SW and KEY.
- The existing seven-segment decoder is reused per digit.

Test Plan:
- Reset: assert reset=0 mid-run → LEDR=0, LEDG=0, all HEX digits = 7-seg "0", rdValid=0 immediately, with no clk edge.
- Store 0x3FF to LEDRV, then load LEDRV → LEDR=10'h3FF; next cycle rdValid=1, rdData=0x3FF. Load offset 0x30 → rdData=0.
- KEY[2] driven low → KSTAT bit2=1 after sync latency. Second press before clear → bit18=1. Store 0x0004_0004 to KSTAT → both cleared. Press coincident with W1C → bit2 stays 1.
- TIMER_DIV=4, TLIM=3, enable: ready sets after 12 clk. Count sequence 0,1,2,0. Leave uncleared 12 more clk → overrun=1. Store TCNT=7 on a tick cycle → reads 7.
- SW toggle 0→0x001 → SSTAT=0x1. Second toggle uncleared → 0x3. Load to non-window addr → rdValid=0, ioHit=0.
- MMIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=8: KEY glitch of 5 cycles → no ready. Hold 8+ cycles → ready set.
